lut_multiplier_seq_ctrl: RTL and testbench

- Sequencer that computes a full OP_WIDTH x OP_WIDTH product by time-multiplexing one 4-bit-slice LUT multiplier datapath (32b x 4b, combinational result) over the multiplier nibbles.
- Each cycle it drives one nibble into the datapath and shift-accumulates the partial product into a 2*OP_WIDTH result.
- Sits between a valid/ready operand source and a valid/ready result sink. The LUT datapath is instantiated beside it, not inside it.

---
 rtl/lut_multiplier_seq_ctrl.sv | 165 ++++++++++++++++
 tb/tb_lut_multiplier_seq_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_multiplier_seq_ctrl.sv
// -----------------------------------------------------------------------------
// lut_multiplier_seq_ctrl
//
// Sequencer that computes an unsigned OP_WIDTH x OP_WIDTH product by walking
// the multiplier one 4-bit nibble per cycle through an external 32b x 4b LUT
// multiplier datapath, shift-accumulating each partial product into a
// 2*OP_WIDTH accumulator.
//
// Ports:
//   clk_seq      - sole clock
//   resetn_seq   - synchronous reset, active HIGH despite the name
//   in_valid     - operand pair valid          (operand source)
//   in_ready     - controller idle, accepts    (operand source)
//   in_a, in_b   - multiplicand / multiplier   (operand source)
//   lut_resetn   - datapath reset; high forces the datapath result to zero
//   lut_src0     - multiplicand to datapath (zero outside RUN)
//   lut_src1     - current multiplier nibble to datapath (zero outside RUN)
//   lut_result   - datapath partial product; only [OP_WIDTH+3:0] is used
//   out_valid    - product valid, held until out_ready
//   out_ready    - sink accepts product
//   out_product  - a*b, unsigned, stable while out_valid
//   busy         - high in RUN or DONE
//   step_cnt     - RUN cycles consumed by the current/last operation
// -----------------------------------------------------------------------------
module lut_multiplier_seq_ctrl #(
    parameter int OP_WIDTH   = 32,
    parameter int NIBBLES    = OP_WIDTH / 4,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                            clk_seq,
    input  logic                            resetn_seq,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [OP_WIDTH-1:0]             in_a,
    input  logic [OP_WIDTH-1:0]             in_b,
    output logic                            lut_resetn,
    output logic [OP_WIDTH-1:0]             lut_src0,
    output logic [3:0]                      lut_src1,
    input  logic [63:0]                     lut_result,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [2*OP_WIDTH-1:0]           out_product,
    output logic                            busy,
    output logic [$clog2(NIBBLES+1)-1:0]    step_cnt
);

    localparam int CNT_W  = $clog2(NIBBLES + 1);
    localparam int PROD_W = 2 * OP_WIDTH;
    localparam int PP_W   = OP_WIDTH + 4;
    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [OP_WIDTH-1:0]  a_r;
    logic [OP_WIDTH-1:0]  b_sh_r;
    logic [OP_WIDTH-1:0]  b_sh_next_s;
    logic [PROD_W-1:0]    acc_r;
    logic [PROD_W-1:0]    partial_s;
    logic [CNT_W-1:0]     idx_r;
    logic [CNT_W-1:0]     step_cnt_r;
    logic                 last_step_s;
    logic                 run_s;
    logic                 lut_hi_unused_s;

    // Upper datapath bits carry nothing meaningful for this operand width.
    assign lut_hi_unused_s = ^lut_result[63:PP_W];

    assign run_s       = (state_r == ST_RUN);
    assign b_sh_next_s = b_sh_r >> 4;
    // Partial product weighted by the nibble position (4 bits per step).
    assign partial_s   = PROD_W'(lut_result[PP_W-1:0]) << {idx_r, 2'b00};

    // Decide whether the current RUN cycle is the final one.
    always_comb begin
        last_step_s = (idx_r == IDX_LAST);
        if (EARLY_EXIT && (b_sh_next_s == '0)) begin
            last_step_s = 1'b1;
        end else begin
            last_step_s = last_step_s;
        end
    end

    // Next-state logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step_s) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // State register plus operand, accumulator and counter datapath.
    always_ff @(posedge clk_seq) begin
        if (resetn_seq) begin
            state_r    <= ST_IDLE;
            a_r        <= '0;
            b_sh_r     <= '0;
            acc_r      <= '0;
            idx_r      <= '0;
            step_cnt_r <= '0;
        end else begin
            state_r <= state_next_s;
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_r        <= in_a;
                        b_sh_r     <= in_b;
                        acc_r      <= '0;
                        idx_r      <= '0;
                        step_cnt_r <= '0;
                    end
                end
                ST_RUN: begin
                    acc_r      <= acc_r + partial_s;
                    b_sh_r     <= b_sh_next_s;
                    idx_r      <= idx_r + CNT_W'(1);
                    step_cnt_r <= step_cnt_r + CNT_W'(1);
                end
                ST_DONE: begin
                    acc_r <= acc_r;
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

    // All outputs decode directly from registered state/datapath values.
    assign in_ready    = (state_r == ST_IDLE);
    assign busy        = (state_r != ST_IDLE);
    assign out_valid   = (state_r == ST_DONE);
    assign out_product = acc_r;
    assign step_cnt    = step_cnt_r;
    assign lut_resetn  = ~run_s;
    assign lut_src0    = run_s ? a_r : '0;
    assign lut_src1    = run_s ? b_sh_r[3:0] : 4'd0;

endmodule

// File: tb/tb_lut_multiplier_seq_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for lut_multiplier_seq_ctrl: two instances (EARLY_EXIT=0 and =1), each
// with a behavioural LUT datapath. A scoreboard queue per instance holds the
// golden product and expected out_valid latency for each accepted operand pair.
// -----------------------------------------------------------------------------
module tb_lut_multiplier_seq_ctrl;

    logic        clk = 1'b0;
    logic        resetn_seq;
    int          cyc = 0;
    int          err_cnt = 0;
    int          chk_cnt = 0;

    typedef struct {
        logic [63:0] prod;
        int          t;
        int          lat;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];

    // instance 0 (EARLY_EXIT=0)
    logic        in_valid0, in_ready0, lut_resetn0, out_valid0, out_ready0, busy0;
    logic [31:0] in_a0, in_b0, lut_src0_0;
    logic [3:0]  lut_src1_0, step_cnt0;
    logic [63:0] lut_result0, out_product0;
    logic [35:0] pp0;
    logic        garbage0;
    // instance 1 (EARLY_EXIT=1)
    logic        in_valid1, in_ready1, lut_resetn1, out_valid1, out_ready1, busy1;
    logic [31:0] in_a1, in_b1, lut_src0_1;
    logic [3:0]  lut_src1_1, step_cnt1;
    logic [63:0] lut_result1, out_product1;
    logic [35:0] pp1;

    logic spacing_en = 1'b0;
    int   last_hs0 = -1;
    logic ov0_prev = 1'b0;
    logic ov1_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // behavioural LUT datapaths
    assign pp0 = lut_resetn0 ? 36'd0 : ({4'd0, lut_src0_0} * {32'd0, lut_src1_0});
    assign lut_result0 = {(garbage0 ? 28'hDEADBEE : 28'd0), pp0};
    assign pp1 = lut_resetn1 ? 36'd0 : ({4'd0, lut_src0_1} * {32'd0, lut_src1_1});
    assign lut_result1 = {28'd0, pp1};

    lut_multiplier_seq_ctrl #(.OP_WIDTH(32), .EARLY_EXIT(1'b0)) u_dut0 (
        .clk_seq(clk), .resetn_seq(resetn_seq),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
        .lut_resetn(lut_resetn0), .lut_src0(lut_src0_0), .lut_src1(lut_src1_0),
        .lut_result(lut_result0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_product(out_product0),
        .busy(busy0), .step_cnt(step_cnt0)
    );

    lut_multiplier_seq_ctrl #(.OP_WIDTH(32), .EARLY_EXIT(1'b1)) u_dut1 (
        .clk_seq(clk), .resetn_seq(resetn_seq),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
        .lut_resetn(lut_resetn1), .lut_src0(lut_src0_1), .lut_src1(lut_src1_1),
        .lut_result(lut_result1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_product(out_product1),
        .busy(busy1), .step_cnt(step_cnt1)
    );

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int ee_steps(input logic [31:0] b);
        for (int i = 7; i >= 0; i--) begin
            if (((b >> (4 * i)) & 32'hF) != 32'd0) return i + 1;
        end
        return 1;
    endfunction

    // scoreboard / monitor for instance 0
    always @(negedge clk) begin
        sb_t e;
        if (resetn_seq) begin
            q0.delete();
            ov0_prev = 1'b0;
        end else begin
            if (out_valid0 && !ov0_prev) begin
                check_eq("pending_on_valid0", 64'(q0.size() != 0), 64'd1);
                if (q0.size() != 0) check_eq("latency0", 64'(cyc - q0[0].t), 64'(q0[0].lat));
            end
            if (out_valid0 && out_ready0 && q0.size() != 0) begin
                e = q0.pop_front();
                check_eq("product0", out_product0, e.prod);
            end
            if (in_valid0 && in_ready0) begin
                e.prod = {32'd0, in_a0} * {32'd0, in_b0};
                e.t    = cyc;
                e.lat  = 9;
                q0.push_back(e);
                if (spacing_en && last_hs0 >= 0) check_eq("spacing0", 64'(cyc - last_hs0), 64'd10);
                last_hs0 = cyc;
            end
            ov0_prev = out_valid0;
        end
    end

    // scoreboard / monitor for instance 1
    always @(negedge clk) begin
        sb_t e;
        if (resetn_seq) begin
            q1.delete();
            ov1_prev = 1'b0;
        end else begin
            if (out_valid1 && !ov1_prev) begin
                check_eq("pending_on_valid1", 64'(q1.size() != 0), 64'd1);
                if (q1.size() != 0) check_eq("latency1", 64'(cyc - q1[0].t), 64'(q1[0].lat));
            end
            if (out_valid1 && out_ready1 && q1.size() != 0) begin
                e = q1.pop_front();
                check_eq("product1", out_product1, e.prod);
            end
            if (in_valid1 && in_ready1) begin
                e.prod = {32'd0, in_a1} * {32'd0, in_b1};
                e.t    = cyc;
                e.lat  = 1 + ee_steps(in_b1);
                q1.push_back(e);
            end
            ov1_prev = out_valid1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // present operands on instance 0 and return just after the accepting edge
    task automatic send0(input logic [31:0] a, input logic [31:0] b);
        logic hs;
        int   n;
        in_a0 = a; in_b0 = b; in_valid0 = 1'b1;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = in_ready0;
            tick();
            n++;
        end
        if (!hs) check_eq("accept_timeout0", 64'(hs), 64'd1);
    endtask

    task automatic send1(input logic [31:0] a, input logic [31:0] b);
        logic hs;
        int   n;
        in_a1 = a; in_b1 = b; in_valid1 = 1'b1;
        n = 0;
        hs = 1'b0;
        while (!hs && n < 100) begin
            @(negedge clk);
            hs = in_ready1;
            tick();
            n++;
        end
        if (!hs) check_eq("accept_timeout1", 64'(hs), 64'd1);
        in_valid1 = 1'b0;
    endtask

    task automatic wait_valid0();
        int n = 0;
        while (!out_valid0 && n < 50) begin
            tick();
            n++;
        end
        check_eq("valid_wait0", 64'(out_valid0), 64'd1);
    endtask

    task automatic wait_valid1();
        int n = 0;
        while (!out_valid1 && n < 50) begin
            tick();
            n++;
        end
        check_eq("valid_wait1", 64'(out_valid1), 64'd1);
    endtask

    initial begin
        #5ms;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] rb;
        int          n;
        resetn_seq = 1'b1;
        in_valid0 = 1'b0; in_a0 = 32'd0; in_b0 = 32'd0; out_ready0 = 1'b1; garbage0 = 1'b0;
        in_valid1 = 1'b0; in_a1 = 32'd0; in_b1 = 32'd0; out_ready1 = 1'b1;
        repeat (3) tick();
        resetn_seq = 1'b0;

        // reset values
        check_eq("rst_in_ready", 64'(in_ready0), 64'd1);
        check_eq("rst_out_valid", 64'(out_valid0), 64'd0);
        check_eq("rst_product", out_product0, 64'd0);
        check_eq("rst_busy", 64'(busy0), 64'd0);
        check_eq("rst_step_cnt", 64'(step_cnt0), 64'd0);
        check_eq("rst_lut_resetn", 64'(lut_resetn0), 64'd1);
        check_eq("rst_lut_src0", 64'(lut_src0_0), 64'd0);
        check_eq("rst_lut_src1", 64'(lut_src1_0), 64'd0);
        check_eq("rst_in_ready1", 64'(in_ready1), 64'd1);

        // 3 * 5, check RUN-time datapath drive and final step count
        send0(32'h3, 32'h5);
        in_valid0 = 1'b0;
        check_eq("run_lut_resetn", 64'(lut_resetn0), 64'd0);
        check_eq("run_lut_src0", 64'(lut_src0_0), 64'h3);
        check_eq("run_lut_src1", 64'(lut_src1_0), 64'h5);
        check_eq("run_busy", 64'(busy0), 64'd1);
        check_eq("run_in_ready", 64'(in_ready0), 64'd0);
        wait_valid0();
        check_eq("done_step_cnt", 64'(step_cnt0), 64'd8);
        check_eq("done_lut_resetn", 64'(lut_resetn0), 64'd1);
        tick();
        check_eq("back_idle", 64'(in_ready0), 64'd1);

        // max operands with sink stall
        out_ready0 = 1'b0;
        send0(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        in_valid0 = 1'b0;
        wait_valid0();
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_valid", 64'(out_valid0), 64'd1);
            check_eq("stall_product", out_product0, 64'hFFFF_FFFE_0000_0001);
            check_eq("stall_in_ready", 64'(in_ready0), 64'd0);
        end
        out_ready0 = 1'b1;
        tick();

        // reset during RUN step 4
        send0(32'hFFFF_FFFF, 32'h2);
        in_valid0 = 1'b0;
        repeat (3) tick();
        check_eq("mid_step_cnt", 64'(step_cnt0), 64'd3);
        resetn_seq = 1'b1;
        tick();
        resetn_seq = 1'b0;
        check_eq("mid_rst_in_ready", 64'(in_ready0), 64'd1);
        check_eq("mid_rst_out_valid", 64'(out_valid0), 64'd0);
        check_eq("mid_rst_busy", 64'(busy0), 64'd0);
        check_eq("mid_rst_step_cnt", 64'(step_cnt0), 64'd0);
        check_eq("mid_rst_product", out_product0, 64'd0);
        check_eq("mid_rst_lut_resetn", 64'(lut_resetn0), 64'd1);
        repeat (12) tick();
        check_eq("mid_rst_no_valid", 64'(out_valid0), 64'd0);
        send0(32'h7, 32'h6);
        in_valid0 = 1'b0;
        wait_valid0();
        check_eq("after_rst_product", out_product0, 64'h2A);
        tick();

        // garbage in unused datapath bits
        garbage0 = 1'b1;
        send0(32'h1, 32'h1);
        in_valid0 = 1'b0;
        wait_valid0();
        check_eq("garbage_product", out_product0, 64'h1);
        tick();
        garbage0 = 1'b0;

        // early-exit instance
        send1(32'h1234_5678, 32'h0000_0010);
        wait_valid1();
        check_eq("ee_product", out_product1, 64'h0000_0001_2345_6780);
        check_eq("ee_step_cnt", 64'(step_cnt1), 64'd2);
        tick();
        send1(32'h1234_5678, 32'h0);
        wait_valid1();
        check_eq("ee_zero_product", out_product1, 64'd0);
        check_eq("ee_zero_step_cnt", 64'(step_cnt1), 64'd1);
        tick();
        for (int i = 0; i < 20; i++) begin
            rb = $urandom() >> (4 * $urandom_range(0, 7));
            send1($urandom(), rb);
            wait_valid1();
            check_eq("ee_rand_step_cnt", 64'(step_cnt1), 64'(ee_steps(rb)));
            tick();
        end

        // back-to-back random stream, in_valid held high
        last_hs0 = -1;
        spacing_en = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            send0($urandom(), $urandom());
        end
        in_valid0 = 1'b0;
        n = 0;
        while ((busy0 || q0.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        spacing_en = 1'b0;
        check_eq("drain_idle", 64'(busy0), 64'd0);
        check_eq("drain_queue0", 64'(q0.size()), 64'd0);
        check_eq("drain_queue1", 64'(q1.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
